// File: rtl/hazard_ctrl.sv
// hazard_ctrl: D-stage hazard / forwarding controller for the 5-stage MIPS pipeline.
// Tracks {valid, dst, tnew, src} for the instructions in E, M and W, derives the
// D-stage freeze, the E-stage bubble and the D-stage forward selects.
// Optional feature macro: MDU_STALL_EN (multiply/divide busy-counter stall).

// Per-source logic: stall decision and forward/bypass select for one D source.
// Stage index in the packed tracker vectors: 0 = E, 1 = M, 2 = W.
module hazard_src (
    input  logic [4:0]      r_i,
    input  logic [1:0]      tuse_i,
    input  logic [2:0]      vld_i,
    input  logic [2:0][4:0] dst_i,
    input  logic [1:0][1:0] tnew_i,
    input  logic [2:0][1:0] src_i,
    output logic            stall_o,
    output logic [2:0]      fsel_o,
    output logic [1:0]      fbyp_o
);
    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_LINK = 2'b10;

    logic [2:0] hit;

    // A stage matches when it holds a live write to this source; $0 never matches.
    always_comb begin
        for (int k = 0; k < 3; k++)
            hit[k] = vld_i[k] && (dst_i[k] == r_i) && (r_i != 5'd0);
    end

    // Stall while the producer in E or M cannot deliver before this source is needed.
    always_comb begin
        stall_o = 1'b0;
        if (tuse_i != 2'd3)
            stall_o = (hit[0] && (tuse_i < tnew_i[0])) ||
                      (hit[1] && (tuse_i < tnew_i[1]));
    end

    // Newest matching stage decides; older stages are shadowed even if they could forward.
    always_comb begin
        fsel_o = 3'b000;
        fbyp_o = 2'b00;
        if (hit[0]) begin
            if (tnew_i[0] == 2'd0 && src_i[0] == SRC_LINK) fsel_o = 3'b100;
        end else if (hit[1]) begin
            case (src_i[1])
                SRC_ALU:  fsel_o = 3'b001;
                SRC_LINK: fsel_o = 3'b101;
                default:  fsel_o = 3'b000;
            endcase
        end else if (hit[2]) begin
            case (src_i[2])
                SRC_ALU:  begin fsel_o = 3'b010; fbyp_o = 2'b01; end
                SRC_LOAD: begin fsel_o = 3'b011; fbyp_o = 2'b01; end
                SRC_LINK: begin fsel_o = 3'b110; fbyp_o = 2'b10; end
                default:  begin fsel_o = 3'b000; fbyp_o = 2'b00; end
            endcase
        end
    end
endmodule

module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [4:0] Rs_D,
    input  logic [4:0] Rt_D,
    input  logic [1:0] TuseRs_D,
    input  logic [1:0] TuseRt_D,
    input  logic [4:0] Dst_D,
    input  logic [1:0] Tnew_D,
    input  logic [1:0] Src_D,
    input  logic       Jr_D,
`ifdef MDU_STALL_EN
    input  logic [1:0] MdStart_D,
    input  logic       MdUse_D,
`endif
    output logic       stall,
    output logic       reset_E,
    output logic [2:0] f_Rs_D,
    output logic [2:0] f_Rt_D,
    output logic [2:0] f_jr_D,
    output logic [1:0] f_RD1_D,
    output logic [1:0] f_RD2_D
);
    typedef struct packed {
        logic       vld;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [1:0] src;
    } trk_t;

    trk_t e_q, e_d, m_q, m_d, w_q, w_d;
    logic md_stall;

    // Tracker advance: E->M->W with tnew counting down to 0; a stall inserts a bubble into E.
    always_comb begin
        m_d      = e_q;
        m_d.tnew = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
        w_d      = m_q;
        w_d.tnew = (m_q.tnew == 2'd0) ? 2'd0 : m_q.tnew - 2'd1;
        if (stall) e_d = '0;
        else       e_d = '{vld: (Dst_D != 5'd0), dst: Dst_D, tnew: Tnew_D, src: Src_D};
    end

    // Tracker registers; RESET wins over stall.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    // W's remaining tnew is always 0 for legal encodings, so the per-source logic ignores it.
    logic unused_w_tnew;
    assign unused_w_tnew = ^w_q.tnew;

    logic [2:0]      vld;
    logic [2:0][4:0] dst;
    logic [1:0][1:0] tnew;
    logic [2:0][1:0] src;
    logic [1:0][4:0] rsel;
    logic [1:0][1:0] tuse;
    logic [1:0]      stl;
    logic [1:0][2:0] fsel;
    logic [1:0][1:0] fbyp;

    assign vld  = {w_q.vld,  m_q.vld,  e_q.vld};
    assign dst  = {w_q.dst,  m_q.dst,  e_q.dst};
    assign tnew = {m_q.tnew, e_q.tnew};
    assign src  = {w_q.src,  m_q.src,  e_q.src};
    assign rsel = {Rt_D, Rs_D};
    assign tuse = {TuseRt_D, TuseRs_D};

    // Source 0 = rs, source 1 = rt.
    generate
        for (genvar g = 0; g < 2; g++) begin : g_src
            hazard_src u_src (
                .r_i    (rsel[g]),
                .tuse_i (tuse[g]),
                .vld_i  (vld),
                .dst_i  (dst),
                .tnew_i (tnew),
                .src_i  (src),
                .stall_o(stl[g]),
                .fsel_o (fsel[g]),
                .fbyp_o (fbyp[g])
            );
        end
    endgenerate

`ifdef MDU_STALL_EN
    logic [3:0] cnt_q, cnt_d;

    // Busy counter: loads only when the start instruction actually leaves D.
    always_comb begin
        cnt_d = cnt_q;
        if (!stall && MdStart_D == 2'b01)      cnt_d = 4'(MULT_CYC);
        else if (!stall && MdStart_D == 2'b10) cnt_d = 4'(DIV_CYC);
        else if (cnt_q != 4'd0)                cnt_d = cnt_q - 4'd1;
    end

    // Busy counter register.
    always_ff @(posedge CLK) begin
        if (RESET) cnt_q <= 4'd0;
        else       cnt_q <= cnt_d;
    end

    assign md_stall = MdUse_D && (cnt_q != 4'd0);
`else
    logic unused_mdu_params;
    assign unused_mdu_params = ^{MULT_CYC, DIV_CYC};
    assign md_stall = 1'b0;
`endif

    // Output drive: bubble E whenever D is frozen; jr select mirrors the rs select.
    always_comb begin
        stall   = stl[0] | stl[1] | md_stall;
        reset_E = stall;
        f_Rs_D  = fsel[0];
        f_Rt_D  = fsel[1];
        f_jr_D  = Jr_D ? fsel[0] : 3'b000;
        f_RD1_D = fbyp[0];
        f_RD2_D = fbyp[1];
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an age-based history model.
module tb_hazard_ctrl;
    localparam logic [1:0] ALU = 2'b00, LOAD = 2'b01, LINK = 2'b10;
    localparam int MULT_CYC = 5, DIV_CYC = 10;

    logic CLK = 1'b0, RESET;
    logic [4:0] Rs_D, Rt_D, Dst_D;
    logic [1:0] TuseRs_D, TuseRt_D, Tnew_D, Src_D;
    logic Jr_D;
    logic stall, reset_E;
    logic [2:0] f_Rs_D, f_Rt_D, f_jr_D;
    logic [1:0] f_RD1_D, f_RD2_D;
`ifdef MDU_STALL_EN
    logic [1:0] MdStart_D;
    logic MdUse_D;
`endif

    int tests = 0, fails = 0;
    logic chk_en = 1'b0;

    always #5 CLK = ~CLK;

    hazard_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .CLK(CLK), .RESET(RESET),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .TuseRs_D(TuseRs_D), .TuseRt_D(TuseRt_D),
        .Dst_D(Dst_D), .Tnew_D(Tnew_D), .Src_D(Src_D), .Jr_D(Jr_D),
`ifdef MDU_STALL_EN
        .MdStart_D(MdStart_D), .MdUse_D(MdUse_D),
`endif
        .stall(stall), .reset_E(reset_E), .f_Rs_D(f_Rs_D), .f_Rt_D(f_Rt_D),
        .f_jr_D(f_jr_D), .f_RD1_D(f_RD1_D), .f_RD2_D(f_RD2_D)
    );

    // Model: history of the last three issued slots, index = age since E entry.
    logic       mv[3];
    logic [4:0] md[3];
    int         mt[3];
    logic [1:0] ms[3];
    int         mcnt = 0;

    function automatic int rem(int age);
        return (mt[age] - age < 0) ? 0 : mt[age] - age;
    endfunction

    function automatic logic src_stall(logic [4:0] r, logic [1:0] t);
        if (r == 0 || t == 2'd3) return 1'b0;
        for (int a = 0; a < 2; a++)
            if (mv[a] && md[a] == r && int'(t) < rem(a)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_stall();
        logic s;
        s = src_stall(Rs_D, TuseRs_D) | src_stall(Rt_D, TuseRt_D);
`ifdef MDU_STALL_EN
        s = s | (MdUse_D && mcnt != 0);
`endif
        return s;
    endfunction

    task automatic fwd(input logic [4:0] r, output logic [2:0] sel, output logic [1:0] byp);
        sel = 3'd0; byp = 2'd0;
        if (r == 0) return;
        for (int a = 0; a < 3; a++) begin
            if (mv[a] && md[a] == r) begin
                if (a == 0) sel = (rem(0) == 0 && ms[0] == LINK) ? 3'd4 : 3'd0;
                else if (a == 1) sel = (ms[1] == ALU) ? 3'd1 : (ms[1] == LINK) ? 3'd5 : 3'd0;
                else begin
                    sel = (ms[2] == ALU) ? 3'd2 : (ms[2] == LOAD) ? 3'd3 : (ms[2] == LINK) ? 3'd6 : 3'd0;
                    byp = (ms[2] == ALU || ms[2] == LOAD) ? 2'd1 : (ms[2] == LINK) ? 2'd2 : 2'd0;
                end
                return;
            end
        end
    endtask

    task automatic model_update();
        logic es;
        es = exp_stall();
        if (RESET) begin
            for (int a = 0; a < 3; a++) mv[a] = 1'b0;
            mcnt = 0;
        end else begin
            for (int a = 2; a > 0; a--) begin
                mv[a] = mv[a-1]; md[a] = md[a-1]; mt[a] = mt[a-1]; ms[a] = ms[a-1];
            end
            mv[0] = !es && Dst_D != 0; md[0] = Dst_D; mt[0] = int'(Tnew_D); ms[0] = Src_D;
`ifdef MDU_STALL_EN
            if (!es && MdStart_D == 2'b01) mcnt = MULT_CYC;
            else if (!es && MdStart_D == 2'b10) mcnt = DIV_CYC;
            else if (mcnt > 0) mcnt = mcnt - 1;
`endif
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Clock edge: advance the model with the inputs that were present at the edge.
    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [1:0] trs, input logic [4:0] rt,
                         input logic [1:0] trt, input logic [4:0] dst, input logic [1:0] tn,
                         input logic [1:0] sr, input logic jr);
        Rs_D = rs; TuseRs_D = trs; Rt_D = rt; TuseRt_D = trt;
        Dst_D = dst; Tnew_D = tn; Src_D = sr; Jr_D = jr;
`ifdef MDU_STALL_EN
        MdStart_D = 2'b00; MdUse_D = 1'b0;
`endif
        #1;
    endtask

    task automatic nop();
        issue(0, 3, 0, 3, 0, 0, ALU, 0);
    endtask

    task automatic flush();
        nop();
        repeat (3) tick();
    endtask

    // Per-cycle compare against the model; selects are don't-care while stalled.
    always @(negedge CLK) begin : cmp
        logic es;
        logic [2:0] s1, s2;
        logic [1:0] b1, b2;
        if (chk_en) begin
            es = exp_stall();
            fwd(Rs_D, s1, b1);
            fwd(Rt_D, s2, b2);
            chk("m_stall", stall, es);
            chk("m_reset_E", reset_E, es);
            if (!es) begin
                chk("m_f_Rs_D", f_Rs_D, s1);
                chk("m_f_Rt_D", f_Rt_D, s2);
                chk("m_f_jr_D", f_jr_D, Jr_D ? s1 : 3'd0);
                chk("m_f_RD1_D", f_RD1_D, b1);
                chk("m_f_RD2_D", f_RD2_D, b2);
            end
        end
    end

    initial begin
        for (int a = 0; a < 3; a++) begin mv[a] = 0; md[a] = 0; mt[a] = 0; ms[a] = 0; end
        RESET = 1'b1;
        nop();
        tick(); tick();
        RESET = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_reset_E", reset_E, 0);
        chk("rst_sel", {f_Rs_D, f_Rt_D, f_RD1_D}, 0);

        // lw $1 then addu $2,$1,$3: one-cycle load-use stall
        issue(0, 3, 0, 3, 1, 2, LOAD, 0); tick();
        issue(1, 1, 3, 1, 2, 1, ALU, 0);
        chk("t1_stall_c1", stall, 1);
        chk("t1_resetE_c1", reset_E, 1);
        tick();
        chk("t1_stall_c2", stall, 0);
        tick(); flush();

        // lw $1 then beq $1,$0: two-cycle stall, then W load forward
        issue(0, 3, 0, 3, 1, 2, LOAD, 0); tick();
        issue(1, 0, 0, 0, 0, 0, ALU, 0);
        chk("t2_stall_c1", stall, 1);
        tick();
        chk("t2_stall_c2", stall, 1);
        tick();
        chk("t2_stall_c3", stall, 0);
        chk("t2_f_Rs", f_Rs_D, 3'b011);
        chk("t2_f_RD1", f_RD1_D, 2'b01);
        tick(); flush();

        // RESET asserted during the load-use stall
        issue(0, 3, 0, 3, 1, 2, LOAD, 0); tick();
        issue(1, 0, 0, 0, 0, 0, ALU, 0);
        chk("t5r_stall_pre", stall, 1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0; #1;
        chk("t5r_stall", stall, 0);
        chk("t5r_sel", {f_Rs_D, f_Rt_D, f_jr_D, f_RD1_D, f_RD2_D}, 0);
        flush();

        // addu $1 then beq $1,$1: one stall cycle, then M ALU forward on both
        issue(0, 3, 0, 3, 1, 1, ALU, 0); tick();
        issue(1, 0, 1, 0, 0, 0, ALU, 0);
        chk("t3_stall_c1", stall, 1);
        tick();
        chk("t3_stall_c2", stall, 0);
        chk("t3_f_Rs", f_Rs_D, 3'b001);
        chk("t3_f_Rt", f_Rt_D, 3'b001);
        tick(); flush();

        // jal then jr $31: link forwarded from E, no stall
        issue(0, 3, 0, 3, 31, 0, LINK, 0); tick();
        issue(31, 0, 0, 3, 0, 0, ALU, 1);
        chk("t4_stall", stall, 0);
        chk("t4_f_Rs", f_Rs_D, 3'b100);
        chk("t4_f_jr", f_jr_D, 3'b100);
        tick(); flush();

        // writes to $0 never hazard
        issue(1, 1, 2, 1, 0, 1, ALU, 0); tick();
        issue(0, 0, 0, 0, 0, 0, ALU, 0);
        chk("t5_stall", stall, 0);
        chk("t5_f_Rs", f_Rs_D, 0);
        chk("t5_f_Rt", f_Rt_D, 0);
        tick(); flush();

`ifdef MDU_STALL_EN
        // mult then mfhi: stalled for MULT_CYC cycles
        nop(); MdStart_D = 2'b01; #1; tick();
        nop(); MdUse_D = 1'b1; #1;
        for (int k = 0; k < MULT_CYC; k++) begin
            chk("t6_stall_busy", stall, 1);
            tick();
        end
        chk("t6_stall_release", stall, 0);
        tick(); flush();
`endif

        // Randomized traffic on a small register set so hazards are frequent
        for (int n = 0; n < 3000; n++) begin
            RESET    = ($urandom_range(0, 59) == 0);
            Rs_D     = 5'($urandom_range(0, 3));
            Rt_D     = 5'($urandom_range(0, 3));
            TuseRs_D = 2'($urandom_range(0, 3));
            TuseRt_D = 2'($urandom_range(0, 3));
            Dst_D    = 5'($urandom_range(0, 3));
            Tnew_D   = 2'($urandom_range(0, 2));
            Src_D    = 2'($urandom_range(0, 2));
            Jr_D     = 1'($urandom_range(0, 1));
`ifdef MDU_STALL_EN
            MdStart_D = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
            MdUse_D   = ($urandom_range(0, 3) == 0);
`endif
            #1;
            tick();
        end
        RESET = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, got running, expected done");
        $fatal(1);
    end
endmodule
